// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 initiator, one WIDTH-bit word per start, MSB first
//
// Purpose:
//   Serialises tx_data_i on mosi_o while capturing miso_i, with sclk_o
//   derived from clk_i by counting CLK_DIV cycles per half-period.
//   The transfer runs IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   Each of SETUP, HOLD and GAP lasts CLK_DIV cycles. SHIFT lasts
//   2*WIDTH half-periods, starting with sclk high.
//
// Parameters:
//   WIDTH   - bits per transfer (>= 1)
//   CLK_DIV - clk cycles per sclk half-period; also the setup/hold/gap length (>= 1)
//
// Ports:
//   clk_i      in   system clock, rising edge
//   rst_i      in   synchronous reset, active high
//   start_i    in   transfer request, sampled only while busy_o = 0
//   tx_data_i  in   word to send, latched on the accepting cycle
//   busy_o     out  high from the cycle after acceptance until the gap completes
//   done_o     out  one-cycle pulse; rx_data_o is valid from this cycle
//   rx_data_o  out  last received word, held until the next done_o
//   sclk_o     out  SPI clock, idle low
//   mosi_o     out  serial data out, MSB first
//   ce0_o      out  chip enable, active low
//   miso_i     in   serial data in, treated as synchronous to clk_i
//
// Configuration:
//   SPI_MASTER_LOOPBACK_EN - when defined, the receive shifter samples the
//   internal mosi register instead of miso_i. rx_data_o then equals the
//   accepted word after every transfer. Pin behaviour is unchanged.

module spi_master #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             sclk_o,
    output logic             mosi_o,
    output logic             ce0_o,
    input  logic             miso_i
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * WIDTH);

    localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST    = HALF_W'(2 * WIDTH - 1);
    // Index of the final high half-period; no new mosi bit follows its fall.
    localparam logic [HALF_W-1:0] HALF_LAST_HI = HALF_W'(2 * WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state_q,   state_d;
    logic [DIV_W-1:0]   div_q,     div_d;
    logic [HALF_W-1:0]  half_q,    half_d;
    logic [WIDTH-1:0]   tx_sr_q,   tx_sr_d;
    logic [WIDTH-1:0]   rx_sr_q,   rx_sr_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               sclk_q,    sclk_d;
    logic               mosi_q,    mosi_d;
    logic               ce0_q,     ce0_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic               div_end;
    logic               rx_in;
    logic [WIDTH-1:0]   tx_shifted;

`ifdef SPI_MASTER_LOOPBACK_EN
    // miso_i is folded in with a zero mask so the pin stays connected
    // but cannot influence the received word.
    assign rx_in = mosi_q | (miso_i & 1'b0);
`else
    assign rx_in = miso_i;
`endif

    assign div_end    = (div_q == DIV_LAST);
    assign tx_shifted = tx_sr_q << 1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            half_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ce0_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ce0_q     <= ce0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        half_d    = half_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ce0_d     = ce0_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ce0_d  = 1'b1;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                div_d  = '0;
                half_d = '0;
                if (start_i) begin
                    tx_sr_d = tx_data_i;
                    mosi_d  = tx_data_i[WIDTH-1];
                    ce0_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                div_d = div_q + DIV_W'(1);
                if (div_end) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                div_d = div_q + DIV_W'(1);
                if (div_end) begin
                    div_d  = '0;
                    half_d = half_q + HALF_W'(1);
                    if (!half_q[0]) begin
                        // End of a high half: capture, drop sclk, and
                        // present the next bit unless this was the last one.
                        rx_sr_d = (rx_sr_q << 1) | WIDTH'(rx_in);
                        sclk_d  = 1'b0;
                        if (half_q != HALF_LAST_HI) begin
                            tx_sr_d = tx_shifted;
                            mosi_d  = tx_shifted[WIDTH-1];
                        end
                    end else if (half_q == HALF_LAST) begin
                        half_d  = '0;
                        state_d = S_HOLD;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                div_d = div_q + DIV_W'(1);
                if (div_end) begin
                    div_d     = '0;
                    ce0_d     = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                    state_d   = S_GAP;
                end
            end

            S_GAP: begin
                div_d = div_q + DIV_W'(1);
                if (div_end) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign ce0_o     = ce0_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed bench for spi_master (WIDTH=8, CLK_DIV=2)

module tb_spi_master;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [7:0] tx_data_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] rx_data_o;
    logic       sclk_o;
    logic       mosi_o;
    logic       ce0_o;
    logic       miso_i;

    spi_master #(.WIDTH(8), .CLK_DIV(2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .tx_data_i (tx_data_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rx_data_o (rx_data_o),
        .sclk_o    (sclk_o),
        .mosi_o    (mosi_o),
        .ce0_o     (ce0_o),
        .miso_i    (miso_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Monitor / mode-0 slave state
    int         cyc = 0;
    logic [7:0] slv_word = 8'h00;
    int         sidx = -1;
    logic       prev_ce0 = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
    logic [7:0] mosi_log, rx_log;
    int         pulses, done_cnt, ce0_low_cnt, ce0_gap_cnt;
    int         ce0_fall_c, first_rise_c, done_c, busy_fall_c;
    bit         busy_fell;

    task automatic clear_log();
        mosi_log = 8'h00; rx_log = 8'h00;
        pulses = 0; done_cnt = 0; ce0_low_cnt = 0; ce0_gap_cnt = 0;
        ce0_fall_c = -1; first_rise_c = -1; done_c = -1; busy_fall_c = -1;
        busy_fell = 1'b0;
    endtask

    always begin
        @(posedge clk_i);
        cyc = cyc + 1;
        #2;
        if (!ce0_o && prev_ce0) begin
            ce0_fall_c = cyc;
            miso_i = slv_word[7];
            sidx = 6;
        end
        if (sclk_o && !prev_sclk) begin
            if (pulses == 0) first_rise_c = cyc;
            mosi_log = {mosi_log[6:0], mosi_o};
            pulses++;
        end
        if (!sclk_o && prev_sclk && sidx >= 0) begin
            miso_i = slv_word[sidx];
            sidx--;
        end
        if (done_o) begin
            done_cnt++;
            done_c = cyc;
            rx_log = rx_data_o;
        end
        if (!ce0_o) ce0_low_cnt++;
        if (ce0_o && busy_o) ce0_gap_cnt++;
        if (!busy_o && prev_busy) begin
            busy_fell = 1'b1;
            busy_fall_c = cyc;
        end
        prev_ce0 = ce0_o; prev_sclk = sclk_o; prev_busy = busy_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] slv);
`ifdef SPI_MASTER_LOOPBACK_EN
        return tx;
`else
        return slv;
`endif
    endfunction

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slv;
        bit         disturb;
    } vec_t;

    // Runs one transfer; returns acceptance cycle number (cycle 0).
    task automatic xfer(input logic [7:0] tx, input logic [7:0] slv, input bit disturb,
                        output int acc);
        for (int i = 0; i < 100 && busy_o; i++) tick();
        clear_log();
        slv_word = slv;
        tx_data_i = tx;
        start_i = 1'b1;
        tick();
        acc = cyc - 1;
        start_i = 1'b0;
        for (int i = 0; i < 100 && !busy_fell; i++) begin
            if (disturb && (i == 8 || i == 20)) begin
                start_i = 1'b1;
                tx_data_i = ~tx;
            end else begin
                start_i = 1'b0;
            end
            tick();
        end
        start_i = 1'b0;
        if (!busy_fell) begin
            errors++;
            $display("FAIL xfer_timeout actual=busy required=idle");
        end
    endtask

    vec_t vecs[5];
    int   acc;
    int   bad;

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 1'b0};
        vecs[1] = '{8'h00, 8'hFF, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b0};
        vecs[3] = '{8'h5A, 8'hFF, 1'b0};
        vecs[4] = '{8'hC3, 8'h81, 1'b1};

        clear_log();
        rst_i = 1'b1; start_i = 1'b0; tx_data_i = 8'h00; miso_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        chk("reset_ce0",  32'(ce0_o),  32'd1);
        chk("reset_sclk", 32'(sclk_o), 32'd0);
        chk("reset_mosi", 32'(mosi_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_rx",   32'(rx_data_o), 32'h00);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ce0_o || sclk_o || mosi_o || busy_o || done_o || rx_data_o != 8'h00) bad++;
            tick();
        end
        chk("idle_20_cycles_bad", 32'(bad), 32'd0);

        for (int v = 0; v < 5; v++) begin
            xfer(vecs[v].tx, vecs[v].slv, vecs[v].disturb, acc);
            tick();
            chk($sformatf("v%0d_ce0_fall", v),   32'(ce0_fall_c - acc),   32'd1);
            chk($sformatf("v%0d_first_rise", v), 32'(first_rise_c - acc), 32'd3);
            chk($sformatf("v%0d_pulses", v),     32'(pulses),             32'd8);
            chk($sformatf("v%0d_mosi_bits", v),  32'(mosi_log),           32'(vecs[v].tx));
            chk($sformatf("v%0d_done_cyc", v),   32'(done_c - acc),       32'd37);
            chk($sformatf("v%0d_done_cnt", v),   32'(done_cnt),           32'd1);
            chk($sformatf("v%0d_rx", v),         32'(rx_log),             32'(exp_rx(vecs[v].tx, vecs[v].slv)));
            chk($sformatf("v%0d_busy_fall", v),  32'(busy_fall_c - acc),  32'd39);
            chk($sformatf("v%0d_ce0_low", v),    32'(ce0_low_cnt),        32'd36);
            chk($sformatf("v%0d_rx_held", v),    32'(rx_data_o),          32'(exp_rx(vecs[v].tx, vecs[v].slv)));
        end

        // Back-to-back with start held high: 0x01 then 0xFF.
        repeat (3) tick();
        clear_log();
        slv_word = 8'h3C;
        tx_data_i = 8'h01;
        start_i = 1'b1;
        tick();
        acc = cyc - 1;
        tx_data_i = 8'hFF;
        repeat (37) tick();                 // now at cycle 38
        slv_word = 8'hC3;
        repeat (3) tick();                  // now at cycle 41
        chk("b2b_first_done_cyc", 32'(done_c - acc),     32'd37);
        chk("b2b_first_rx",       32'(rx_log),           32'(exp_rx(8'h01, 8'h3C)));
        chk("b2b_first_mosi",     32'(mosi_log),         32'h01);
        chk("b2b_ce0_gap_cycles", 32'(ce0_gap_cnt),      32'd2);
        chk("b2b_second_accept",  32'(ce0_fall_c - acc), 32'd40);
        start_i = 1'b0;
        clear_log();
        for (int i = 0; i < 100 && !busy_fell; i++) tick();
        tick();
        chk("b2b_second_done_cyc", 32'(done_c - acc), 32'd76);
        chk("b2b_second_rx",       32'(rx_log),       32'(exp_rx(8'hFF, 8'hC3)));
        chk("b2b_second_mosi",     32'(mosi_log),     32'hFF);
        chk("b2b_second_pulses",   32'(pulses),       32'd8);

        // Reset at cycle 15 of a transfer.
        repeat (3) tick();
        clear_log();
        slv_word = 8'h96;
        tx_data_i = 8'h6E;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (14) tick();                 // now at cycle 15
        rst_i = 1'b1;
        tick();                             // cycle 16
        rst_i = 1'b0;
        chk("rst_mid_ce0",  32'(ce0_o),     32'd1);
        chk("rst_mid_sclk", 32'(sclk_o),    32'd0);
        chk("rst_mid_mosi", 32'(mosi_o),    32'd0);
        chk("rst_mid_busy", 32'(busy_o),    32'd0);
        chk("rst_mid_done", 32'(done_o),    32'd0);
        chk("rst_mid_rx",   32'(rx_data_o), 32'h00);
        repeat (40) tick();
        chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
        xfer(8'h6E, 8'h96, 1'b0, acc);
        tick();
        chk("post_rst_done_cyc", 32'(done_c - acc), 32'd37);
        chk("post_rst_rx",       32'(rx_log),       32'(exp_rx(8'h6E, 8'h96)));
        chk("post_rst_mosi",     32'(mosi_log),     32'h6E);

        // rst and start in the same cycle: start is dropped.
        repeat (3) tick();
        rst_i = 1'b1;
        start_i = 1'b1;
        tx_data_i = 8'h11;
        tick();
        rst_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk("rst_start_busy", 32'(busy_o), 32'd0);
        chk("rst_start_ce0",  32'(ce0_o),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 initiator: the controller end of the four-wire link whose responder sits on the Raspberry Pi/icestick boundary (`sclk`, `mosi`, `ce0`, `miso`). It runs entirely in the `clk` domain and derives `sclk` by counting `clk` cycles. It serialises one `WIDTH`-bit word MSB-first per `start` request and returns the word captured from `miso` in the same transfer. It is used as a bench/bring-up driver for the slave and as a host port for on-board SPI peripherals.

## Interface
- `WIDTH`, 8, bits per transfer; legal range ≥ 1.
- `CLK_DIV`, 2, `clk` cycles per `sclk` half-period (also the setup, hold and gap length); legal range ≥ 1.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  transfer request; sampled only while `busy`=0.
- `tx_data`  in  WIDTH  word to send; latched on the accepting cycle.
- `busy`  out  1  high from the cycle after acceptance until the gap completes.
- `done`  out  1  one-cycle pulse; `rx_data` is valid from this cycle.
- `rx_data`  out  WIDTH  last received word; held until the next `done`.
- `sclk`  out  1  SPI clock, idle low (CPOL=0).
- `mosi`  out  1  serial data out, MSB first.
- `ce0`  out  1  chip enable, active low.
- `miso`  in  1  serial data in.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: `ce0`=1, `sclk`=0, `busy`=0. `start`=1 latches `tx_data` into the shift register and moves to SETUP.
- SETUP (CLK_DIV cycles):
  - `ce0`=0 and `mosi`=tx bit WIDTH-1.
  - `sclk` stays low.
- SHIFT (2·WIDTH half-periods of CLK_DIV cycles each):
  - `sclk` alternates high then low, starting with high.
  - At the clk edge that ends each high half-period, shift `miso` into the receive register LSB.
  - At each falling `sclk`, except the last, present the next lower tx bit on `mosi`.
- HOLD (CLK_DIV cycles): `sclk`=0, `ce0`=0, `mosi` holds bit 0.
- GAP (CLK_DIV cycles):
  - `ce0`=1.
  - In the first GAP cycle, `done`=1 and `rx_data` is updated.
  - `busy` stays high through GAP.
- `start` while `busy`=1 is ignored: no queueing and no effect on the transfer in progress.
- `tx_data` changes after acceptance have no effect.
- Reset values: `ce0`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0. State returns to IDLE.
- `rst` mid-transfer abandons the transfer; the outputs take their reset values on the next cycle and no `done` is issued.
- `rst` and `start` in the same cycle: `rst` wins and `start` is dropped.
- Outputs `sclk`, `mosi` and `ce0` are registered; there are no combinational paths from inputs to pins.

## Timing
- Acceptance at cycle 0 → `ce0` low and `busy` high at cycle 1.
- The first `sclk` rise is at cycle 1+CLK_DIV.
- `ce0` is low for exactly (2·WIDTH+2)·CLK_DIV cycles.
- `done` and `ce0`=1 occur at cycle 1+(2·WIDTH+2)·CLK_DIV.
- `busy` falls CLK_DIV cycles after `done`. A new `start` is accepted on the first cycle with `busy`=0.
- Example, WIDTH=8 and CLK_DIV=2:
  - `ce0` low in cycles 1–36.
  - `done` at cycle 37.
  - `busy`=0 at cycle 39.
  - `sclk` frequency is `clk`/4.
- `miso` is sampled CLK_DIV cycles after the `sclk` rise, immediately before the fall. A mode-0 slave that updates on the falling edge therefore has a full half-period of setup.
- `miso` is treated as synchronous to `clk`. No synchroniser is included; the board guarantees `miso` timing relative to `sclk`.

## Configuration
- `SPI_MASTER_LOOPBACK_EN` defined:
  - The receive shifter takes the internal `mosi` register instead of the `miso` pin, and the `miso` pin is ignored.
  - `rx_data` equals the accepted `tx_data` after every transfer.
  - Pin behaviour is otherwise identical.
- Not defined: the receive shifter samples the `miso` pin as above.

## Test plan
- Reset then idle, WIDTH=8, CLK_DIV=2: `ce0`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0x00 → remain so for 20 cycles with `start`=0.
- Single transfer, `tx_data`=0xA5, slave model returns 0x3C:
  - `mosi` bits 1,0,1,0,0,1,0,1 observed on `sclk` rises.
  - 8 `sclk` pulses.
  - `done` at cycle 37 with `rx_data`=0x3C.
  - `busy`=0 at cycle 39.
- Back-to-back: `start` held high continuously with 0x01 then 0xFF → second acceptance at cycle 39; `ce0` high for exactly 2 cycles (37–38) between words; both words received correctly.
- `start` pulsed and `tx_data` changed mid-transfer → ignored; transmitted word unchanged; exactly one `done`.
- `rst` asserted at cycle 15 of a transfer → cycle 16 shows all reset values; no `done`; the next `start` performs a full clean transfer.
- With `SPI_MASTER_LOOPBACK_EN` defined, `miso` tied to 1, `tx_data`=0x5A → `rx_data`=0x5A at `done`.
